mem_dev_bank: RTL and testbench
===============================

// Module: mem_dev_bank
// PURPOSE
// - Single-bank DRAM-style device: responder end of the mem_ctrl command bus (command/RA/CA/cs_n/DQ).
// - Decodes ACT/READ/WRITE/PRE/REFRESH, enforces bank timing, stores data, returns read data on DQ after CAS latency.
// - Used as the memory behind mem_ctrl in block and system benches; synthesizable except for array size.
// PARAMETERS
// - DATA_W 32  : DQ width
// - ROW_W  4   : RA width
// - COL_W  12  : CA width; array depth = 2**(ROW_W+COL_W)
// - TRCD   5   : min cycles ACT -> READ/WRITE
// - CL     2   : READ command -> DQ data cycles (>=1)
// - TRP    4   : PRE -> next ACT/REFRESH cycles
// - TRFC   5   : REFRESH -> next command cycles
// - TREFI  320 : cycles allowed between REFRESH commands
// PORTS
// - clk          in    1       rising-edge clock
// - rst_n        in    1       asynchronous active-low reset
// - cs_n         in    1       chip select, active low; command ignored (NOP) when 1
// - command      in    3       NOP=000 ACT=001 READ=010 WRITE=011 PRE=100 REFRESH=101; 110/111 = NOP
// - RA           in    ROW_W   row address, sampled with ACT (checked on READ/WRITE)
// - CA           in    COL_W   column address, sampled with READ/WRITE
// - DQ           inout DATA_W  write data in (WRITE cycle), read data out (CL cycles after READ)
// - row_open     out   1       1 while bank ACTIVE
// - open_row     out   ROW_W   latched row; valid when row_open
// - busy         out   1       1 in ACTIVATING/PRECHARGING/REFRESHING
// - refresh_due  out   1       cycles since last REFRESH >= TREFI
// - viol         out   1       one-cycle pulse on protocol/timing violation
// - viol_code    out   3       code for viol cycle: 1 early cmd, 2 rd/wr w/o open row, 3 ACT on open row,
//                              4 row mismatch, 5 DQ contention, 6 REFRESH on open row; 0 otherwise
// BEHAVIOUR
// - States: IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING; one down-counter tcnt.
// - Reset (async): IDLE, tcnt=0, row_open=0, open_row=0, busy=0, refresh_due=0, viol=0, viol_code=0,
//   read pipe cleared, DQ released to Z immediately; array contents NOT cleared.
// - IDLE: ACT -> open_row<=RA, ACTIVATING, tcnt=TRCD-1; REFRESH -> REFRESHING, tcnt=TRFC-1, ref counter=0;
//   PRE -> no-op; READ/WRITE -> ignored, viol code 2.
// - ACTIVATING: tcnt=0 -> ACTIVE (first legal READ/WRITE = ACT cycle + TRCD); any non-NOP -> ignored, code 1.
// - ACTIVE: READ -> sample mem[{open_row,CA}] into read pipe; WRITE -> mem[{open_row,CA}]<=DQ same edge;
//   RA!=open_row on READ/WRITE -> op executes on open_row, code 4; PRE -> PRECHARGING, tcnt=TRP-1;
//   ACT -> ignored, code 3; REFRESH -> ignored, code 6.
// - PRECHARGING/REFRESHING: tcnt=0 -> IDLE; any non-NOP -> ignored, code 1.
// - Read pipe: CL-deep valid+data shift register; READ at edge n drives DQ for exactly the cycle after edge n+CL;
//   back-to-back READs stream one word per cycle; data is array value at READ edge (later WRITE not visible).
// - DQ driven only when pipe output valid, else Z. WRITE while device drives DQ -> write dropped, code 5.
// - PRE/ACT while reads in pipe: pipe drains normally (data already sampled).
// - Refresh counter saturates at TREFI; refresh_due combinational from it; cleared on accepted REFRESH.
// - Multiple violations in one cycle impossible (one command per cycle); viol_code reflects that command.
// CONFIGURATION
// - MEM_DEV_TIMING_CHK_EN defined: full checks as above; commands in busy states / illegal states ignored and flagged.
// - Not defined: viol=0, viol_code=0 constant; early commands in busy states still ignored; READ/WRITE with
//   no open row ignored; row mismatch executes silently; DQ contention still drops the write.
// TESTING
// - Reset, ACT RA=3, wait 5, WRITE CA=0x010 DQ=0xDEADBEEF, READ CA=0x010 -> DQ=0xDEADBEEF exactly 2 cycles after READ.
// - ACT then READ 3 cycles later -> ignored, viol pulse code 1, DQ stays Z, row_open=0 until TRCD elapses.
// - 4 back-to-back READs CA=0..3 after writes 0xA0..0xA3 -> DQ 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
// - 320 cycles with no REFRESH -> refresh_due=1; REFRESH in IDLE -> refresh_due=0 next cycle, busy=1 for 5 cycles.
// - ACT on open row -> code 3; PRE -> busy 4 cycles, then ACT RA=5 accepted, open_row=5.
// - Assert rst_n=0 with read in pipe -> DQ Z immediately, state IDLE; prior written data readable after re-ACT.

Source files
------------

// File: rtl/mem_dev_bank_if.sv
// Command bus between mem_ctrl (master) and the DRAM-style bank (slave).
// DQ is bidirectional and travels outside this bundle as an inout port.
interface mem_dev_bank_if #(
   parameter int ROW_W = 4,
   parameter int COL_W = 12
);
   logic             cs_n;
   logic [2:0]       command;
   logic [ROW_W-1:0] RA;
   logic [COL_W-1:0] CA;

   modport master (output cs_n, command, RA, CA);
   modport slave  (input  cs_n, command, RA, CA);
endinterface

// File: rtl/mem_dev_bank.sv
// Single-bank DRAM-style device: decodes ACT/READ/WRITE/PRE/REFRESH,
// enforces bank timing, stores data and returns reads on DQ after CL.
// Optional macro MEM_DEV_TIMING_CHK_EN enables viol/viol_code reporting.
module mem_dev_bank #(
   parameter int DATA_W = 32,
   parameter int ROW_W  = 4,
   parameter int COL_W  = 12,
   parameter int TRCD   = 5,
   parameter int CL     = 2,
   parameter int TRP    = 4,
   parameter int TRFC   = 5,
   parameter int TREFI  = 320
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_dev_bank_if.slave     bus,
   inout  wire  [DATA_W-1:0] DQ,
   output logic              row_open,
   output logic [ROW_W-1:0]  open_row,
   output logic              busy,
   output logic              refresh_due,
   output logic              viol,
   output logic [2:0]        viol_code
);

   localparam int AW  = ROW_W + COL_W;
   localparam int TW  = 8;
   localparam int RCW = $clog2(TREFI + 1);

   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_ACT   = 3'd1;
   localparam logic [2:0] CMD_READ  = 3'd2;
   localparam logic [2:0] CMD_WRITE = 3'd3;
   localparam logic [2:0] CMD_PRE   = 3'd4;
   localparam logic [2:0] CMD_REF   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVATING,
      S_ACTIVE,
      S_PRECHARGING,
      S_REFRESHING
   } state_e;

   state_e            state_q, state_d, base;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [ROW_W-1:0]  open_row_q, open_row_d;
   logic [RCW-1:0]    ref_cnt_q, ref_cnt_d;
   logic              viol_q, viol_d;
   logic [2:0]        viol_code_q, viol_code_d;
   logic [CL:0]       rd_vld_q, rd_vld_d;
   logic [DATA_W-1:0] rd_dat_q [CL+1];
   logic [DATA_W-1:0] mem [2**AW];

   logic [2:0]        cmd;
   logic [2:0]        code;
   logic              t_done;
   logic              rd_en;
   logic              wr_en;
   logic              ref_ok;
   logic              dq_oe;
   logic              row_hit;
   logic [AW-1:0]     addr;

   assign dq_oe   = rd_vld_q[CL];
   assign DQ      = dq_oe ? rd_dat_q[CL] : 'z;
   assign addr    = {open_row_q, bus.CA};
   assign row_hit = (bus.RA == open_row_q);

   // Command decode against the effective state; an expired timer
   // lets the command on that edge be treated as already settled.
   always_comb begin
      cmd = (bus.cs_n || bus.command > CMD_REF) ? CMD_NOP : bus.command;
      t_done = (tcnt_q == '0);
      base = state_q;
      if (state_q == S_ACTIVATING && t_done)
         base = S_ACTIVE;
      if ((state_q == S_PRECHARGING || state_q == S_REFRESHING) && t_done)
         base = S_IDLE;
      state_d = base;
      tcnt_d = t_done ? tcnt_q : tcnt_q - TW'(1);
      open_row_d = open_row_q;
      rd_en = 1'b0;
      wr_en = 1'b0;
      ref_ok = 1'b0;
      code = 3'd0;
      case (base)
         S_IDLE: begin
            case (cmd)
               CMD_ACT: begin
                  open_row_d = bus.RA;
                  state_d = S_ACTIVATING;
                  tcnt_d = TW'(TRCD - 1);
               end
               CMD_REF: begin
                  ref_ok = 1'b1;
                  state_d = S_REFRESHING;
                  tcnt_d = TW'(TRFC - 1);
               end
               CMD_READ, CMD_WRITE: code = 3'd2;
               default: ;
            endcase
         end
         S_ACTIVE: begin
            case (cmd)
               CMD_READ: begin
                  rd_en = 1'b1;
                  if (!row_hit)
                     code = 3'd4;
               end
               CMD_WRITE: begin
                  if (dq_oe) begin
                     code = 3'd5;
                  end else begin
                     wr_en = 1'b1;
                     if (!row_hit)
                        code = 3'd4;
                  end
               end
               CMD_PRE: begin
                  state_d = S_PRECHARGING;
                  tcnt_d = TW'(TRP - 1);
               end
               CMD_ACT: code = 3'd3;
               CMD_REF: code = 3'd6;
               default: ;
            endcase
         end
         default: begin
            if (cmd != CMD_NOP)
               code = 3'd1;
         end
      endcase
      if (ref_ok)
         ref_cnt_d = '0;
      else if (ref_cnt_q >= RCW'(TREFI))
         ref_cnt_d = ref_cnt_q;
      else
         ref_cnt_d = ref_cnt_q + RCW'(1);
      rd_vld_d = {rd_vld_q[CL-1:0], rd_en};
`ifdef MEM_DEV_TIMING_CHK_EN
      viol_d = (code != 3'd0);
      viol_code_d = code;
`else
      viol_d = 1'b0;
      viol_code_d = 3'd0;
`endif
   end

`ifndef MEM_DEV_TIMING_CHK_EN
   logic unused_code;
   assign unused_code = ^code;
`endif

   // Bank state, timer, row latch, refresh counter and read valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tcnt_q      <= '0;
         open_row_q  <= '0;
         ref_cnt_q   <= '0;
         viol_q      <= 1'b0;
         viol_code_q <= 3'd0;
         rd_vld_q    <= '0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         open_row_q  <= open_row_d;
         ref_cnt_q   <= ref_cnt_d;
         viol_q      <= viol_d;
         viol_code_q <= viol_code_d;
         rd_vld_q    <= rd_vld_d;
      end
   end

   // Array and read-data shift path; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[addr] <= DQ;
      if (rd_en)
         rd_dat_q[0] <= mem[addr];
      for (int k = 1; k <= CL; k++)
         rd_dat_q[k] <= rd_dat_q[k-1];
   end

   assign row_open    = (state_q == S_ACTIVE);
   assign open_row    = open_row_q;
   assign busy        = (state_q == S_ACTIVATING) ||
                        (state_q == S_PRECHARGING) ||
                        (state_q == S_REFRESHING);
   assign refresh_due = (ref_cnt_q >= RCW'(TREFI));
   assign viol        = viol_q;
   assign viol_code   = viol_code_q;

endmodule

// File: tb/tb_mem_dev_bank.sv
// Directed bench for mem_dev_bank: one task per scenario, inline checks.
// Violation expectations follow MEM_DEV_TIMING_CHK_EN when defined.
module tb_mem_dev_bank;

   localparam int DW = 32;
   localparam int RW = 4;
   localparam int CW = 12;
   localparam logic [2:0] NOP = 3'd0;
   localparam logic [2:0] ACT = 3'd1;
   localparam logic [2:0] RD  = 3'd2;
   localparam logic [2:0] WR  = 3'd3;
   localparam logic [2:0] PRE = 3'd4;
   localparam logic [2:0] REF = 3'd5;
`ifdef MEM_DEV_TIMING_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tb_oe = 1'b0;
   logic [DW-1:0] tb_dq = '0;
   wire  [DW-1:0] dq;
   logic          row_open;
   logic [RW-1:0] open_row;
   logic          busy;
   logic          refresh_due;
   logic          viol;
   logic [2:0]    viol_code;
   int            n_run = 0;
   int            n_fail = 0;

   mem_dev_bank_if #(.ROW_W(RW), .COL_W(CW)) bus ();

   assign dq = tb_oe ? tb_dq : 'z;

   mem_dev_bank dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .DQ(dq),
      .row_open(row_open),
      .open_row(open_row),
      .busy(busy),
      .refresh_due(refresh_due),
      .viol(viol),
      .viol_code(viol_code)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [2:0] c, input logic [RW-1:0] ra,
                       input logic [CW-1:0] ca, input logic [DW-1:0] d);
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.command = c;
      bus.RA = ra;
      bus.CA = ca;
      tb_oe = (c == WR);
      tb_dq = d;
   endtask

   task automatic nop();
      step(NOP, '0, '0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.cs_n = 1'b1;
      bus.command = NOP;
      bus.RA = '0;
      bus.CA = '0;
      tb_oe = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_run++;
      if (row_open !== 1'b0) begin
         n_fail++; $display("FAIL reset_row_open got %b exp 0", row_open);
      end
      n_run++;
      if (open_row !== 4'd0) begin
         n_fail++; $display("FAIL reset_open_row got %h exp 0", open_row);
      end
      n_run++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b exp 0", busy);
      end
      n_run++;
      if (refresh_due !== 1'b0) begin
         n_fail++; $display("FAIL reset_refresh_due got %b exp 0", refresh_due);
      end
      n_run++;
      if (viol !== 1'b0 || viol_code !== 3'd0) begin
         n_fail++; $display("FAIL reset_viol got %b/%0d exp 0/0", viol, viol_code);
      end
      n_run++;
      if (dut.dq_oe !== 1'b0) begin
         n_fail++; $display("FAIL reset_dq_drive got %b exp 0", dut.dq_oe);
      end
   endtask

   task automatic test_refresh();
      int bcnt;
      do_reset();
      repeat (319) nop();
      n_run++;
      if (refresh_due !== 1'b0) begin
         n_fail++; $display("FAIL refresh_due_319 got %b exp 0", refresh_due);
      end
      nop();
      n_run++;
      if (refresh_due !== 1'b1) begin
         n_fail++; $display("FAIL refresh_due_320 got %b exp 1", refresh_due);
      end
      step(REF, '0, '0, '0);
      nop();
      n_run++;
      if (refresh_due !== 1'b0) begin
         n_fail++; $display("FAIL refresh_clear got %b exp 0", refresh_due);
      end
      bcnt = busy ? 1 : 0;
      repeat (7) begin
         nop();
         if (busy) bcnt++;
      end
      n_run++;
      if (bcnt != 5) begin
         n_fail++; $display("FAIL refresh_busy_cycles got %0d exp 5", bcnt);
      end
   endtask

   task automatic test_basic_rw();
      step(ACT, 4'd3, '0, '0);
      repeat (4) nop();
      step(WR, 4'd3, 12'h010, 32'hDEADBEEF);
      nop();
      n_run++;
      if (row_open !== 1'b1 || open_row !== 4'd3) begin
         n_fail++;
         $display("FAIL rw_row got %b/%h exp 1/3", row_open, open_row);
      end
      step(RD, 4'd3, 12'h010, '0);
      for (int j = 0; j < 4; j++) begin
         nop();
         n_run++;
         if (dut.dq_oe !== (j == 2)) begin
            n_fail++;
            $display("FAIL rw_dq_drive[%0d] got %b exp %b", j, dut.dq_oe, j == 2);
         end
         if (j == 2) begin
            n_run++;
            if (dq !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL rw_data got %h exp deadbeef", dq);
            end
         end
      end
   endtask

   task automatic test_early_cmd();
      logic drv;
      step(PRE, '0, '0, '0);
      repeat (3) nop();
      step(ACT, 4'd2, '0, '0);
      nop();
      nop();
      step(RD, 4'd2, 12'h000, '0);
      nop();
      n_run++;
      if (viol !== CHK || viol_code !== (CHK ? 3'd1 : 3'd0)) begin
         n_fail++;
         $display("FAIL early_viol got %b/%0d exp %b/%0d", viol, viol_code, CHK, CHK ? 1 : 0);
      end
      drv = dut.dq_oe;
      nop();
      n_run++;
      if (row_open !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL early_row_closed got %b/%b exp 0/1", row_open, busy);
      end
      drv |= dut.dq_oe;
      nop();
      n_run++;
      if (row_open !== 1'b1) begin
         n_fail++; $display("FAIL early_row_open got %b exp 1", row_open);
      end
      drv |= dut.dq_oe;
      repeat (2) begin
         nop();
         drv |= dut.dq_oe;
      end
      n_run++;
      if (drv !== 1'b0) begin
         n_fail++; $display("FAIL early_dq_drive got %b exp 0", drv);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]    c;
      logic [RW-1:0] ra;
      logic          eoe;
      for (int i = 0; i < 4; i++)
         step(WR, 4'd2, CW'(i), 32'hA0 + DW'(i));
      step(RD, 4'd2, 12'd0, '0);
      for (int j = 0; j < 8; j++) begin
         c = (j < 3) ? RD : NOP;
         ra = (j == 1) ? 4'd9 : 4'd2;
         step(c, ra, CW'(j + 1), '0);
         eoe = (j >= 2 && j <= 5);
         n_run++;
         if (dut.dq_oe !== eoe) begin
            n_fail++;
            $display("FAIL b2b_dq_drive[%0d] got %b exp %b", j, dut.dq_oe, eoe);
         end
         if (eoe) begin
            n_run++;
            if (dq !== 32'hA0 + DW'(j - 2)) begin
               n_fail++;
               $display("FAIL b2b_data[%0d] got %h exp %h", j, dq, 32'hA0 + DW'(j - 2));
            end
         end
         if (j == 2) begin
            n_run++;
            if (viol !== CHK || viol_code !== (CHK ? 3'd4 : 3'd0)) begin
               n_fail++;
               $display("FAIL b2b_row_mismatch got %b/%0d exp %b/%0d", viol, viol_code, CHK, CHK ? 4 : 0);
            end
         end
      end
   endtask

   task automatic test_act_open_pre();
      int bcnt;
      step(ACT, 4'd7, '0, '0);
      nop();
      n_run++;
      if (viol !== CHK || viol_code !== (CHK ? 3'd3 : 3'd0)) begin
         n_fail++;
         $display("FAIL act_open_viol got %b/%0d exp %b/%0d", viol, viol_code, CHK, CHK ? 3 : 0);
      end
      n_run++;
      if (open_row !== 4'd2 || row_open !== 1'b1) begin
         n_fail++;
         $display("FAIL act_open_row got %h/%b exp 2/1", open_row, row_open);
      end
      nop();
      n_run++;
      if (viol !== 1'b0) begin
         n_fail++; $display("FAIL act_open_pulse got %b exp 0", viol);
      end
      step(PRE, '0, '0, '0);
      bcnt = 0;
      repeat (3) begin
         nop();
         if (busy) bcnt++;
      end
      step(ACT, 4'd5, '0, '0);
      if (busy) bcnt++;
      n_run++;
      if (bcnt != 4) begin
         n_fail++; $display("FAIL pre_busy_cycles got %0d exp 4", bcnt);
      end
      nop();
      n_run++;
      if (open_row !== 4'd5 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_act_row got %h/%b exp 5/1", open_row, busy);
      end
      repeat (5) nop();
      n_run++;
      if (row_open !== 1'b1) begin
         n_fail++; $display("FAIL pre_act_open got %b exp 1", row_open);
      end
   endtask

   task automatic test_contention();
      step(WR, 4'd5, 12'h005, 32'h11);
      step(RD, 4'd5, 12'h005, '0);
      nop();
      nop();
      step(WR, 4'd5, 12'h005, 32'h55);
      n_run++;
      if (dut.dq_oe !== 1'b1) begin
         n_fail++; $display("FAIL cont_dq_drive got %b exp 1", dut.dq_oe);
      end
      nop();
      n_run++;
      if (viol !== CHK || viol_code !== (CHK ? 3'd5 : 3'd0)) begin
         n_fail++;
         $display("FAIL cont_viol got %b/%0d exp %b/%0d", viol, viol_code, CHK, CHK ? 5 : 0);
      end
      step(RD, 4'd5, 12'h005, '0);
      repeat (3) nop();
      n_run++;
      if (dut.dq_oe !== 1'b1 || dq !== 32'h11) begin
         n_fail++;
         $display("FAIL cont_write_dropped got %b/%h exp 1/00000011", dut.dq_oe, dq);
      end
   endtask

   task automatic test_reset_midread();
      step(RD, 4'd5, 12'h005, '0);
      repeat (3) nop();
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (dut.dq_oe !== 1'b0) begin
         n_fail++; $display("FAIL rst_dq_release got %b exp 0", dut.dq_oe);
      end
      n_run++;
      if (row_open !== 1'b0 || busy !== 1'b0 || open_row !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_state got %b/%b/%h exp 0/0/0", row_open, busy, open_row);
      end
      do_reset();
      step(ACT, 4'd3, '0, '0);
      repeat (4) nop();
      step(RD, 4'd3, 12'h010, '0);
      repeat (3) nop();
      n_run++;
      if (dut.dq_oe !== 1'b1 || dq !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rst_data_kept got %b/%h exp 1/deadbeef", dut.dq_oe, dq);
      end
   endtask

   initial begin
      bus.cs_n = 1'b1;
      bus.command = NOP;
      bus.RA = '0;
      bus.CA = '0;
      test_reset();
      test_refresh();
      test_basic_rw();
      test_early_cmd();
      test_back_to_back();
      test_act_open_pre();
      test_contention();
      test_reset_midread();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
